// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI mode-0 slave receiver for 16-bit register-write frames.
// Frame layout (MSB first): bit 15 R/W (1 = write), bits 14:8 address, bits 7:0 data.
// All SPI pins are synchronised into the clk domain and edge-detected there.
module spi_frame_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       sdi,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [4:0] FRAME_BITS = 5'd16;
    localparam logic [4:0] CNT_SAT    = 5'd17;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sclk_hist;
    logic                   ncs_hist;
    logic [SYNC_STAGES:0]   fill;
    logic                   armed;

    logic                   sclk_s;
    logic                   ncs_s;
    logic                   sdi_s;
    logic                   sclk_rise;
    logic                   ncs_fall;
    logic                   ncs_rise;
    logic                   settled;

    logic [1:0]             state;
    logic [15:0]            shift_q;
    logic [4:0]             bit_cnt;

    logic                   frame_full;
    logic                   frame_wr;
    logic                   addr_ok;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign ncs_fall  = ~ncs_s & ncs_hist;
    assign ncs_rise  = ncs_s & ~ncs_hist;
    assign settled   = fill[SYNC_STAGES];

    assign frame_full = (bit_cnt == FRAME_BITS);
    assign frame_wr   = shift_q[15];
    assign addr_ok    = (shift_q[14:8] <= MAX_ADDR);

    assign busy = (state != IDLE);

    // Synchronise SPI pins; ncs idles high so its chain and history reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            ncs_sync  <= '1;
            sdi_sync  <= '0;
            sclk_hist <= 1'b0;
            ncs_hist  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sclk_hist <= sclk_s;
            ncs_hist  <= ncs_s;
        end
    end

    // Arm frame start only after the synchronizer holds real samples and ncs has
    // been seen high; otherwise ncs held low across reset would look like a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill  <= '0;
            armed <= 1'b0;
        end else begin
            fill <= {fill[SYNC_STAGES-1:0], 1'b1};
            if (settled && ncs_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Frame FSM, shift register, bit counter and commit/reject strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall && armed) begin
                        state   <= SHIFT;
                        shift_q <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        // Strobes are registered on the edge entering DONE so they
                        // are high exactly while the FSM sits in DONE.
                        state <= DONE;
                        if (frame_full && frame_wr && addr_ok) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= shift_q[14:8];
                            wr_data  <= shift_q[7:0];
                        end else if (!(frame_full && !frame_wr)) begin
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_rise && !ncs_s) begin
                        shift_q <= {shift_q[14:0], sdi_s};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: directed SPI frames with a scoreboard of expected strobes.
module tb_spi_frame_rx;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       ncs;
    logic       sdi;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic       busy;

    typedef struct {
        bit         is_err;
        logic [6:0] addr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total;
    int   n_pass;
    int   cyc;

    // Expected held write registers after all frames so far.
    logic [6:0] held_addr;
    logic [7:0] held_data;

    spi_frame_rx #(
        .SYNC_STAGES(2),
        .MAX_ADDR   (7'h04)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .ncs      (ncs),
        .sdi      (sdi),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends n sclk pulses of a 16-bit word MSB first (zeros past bit 16),
    // sclk = clk/8, then raises ncs and returns the cycle of that rise.
    task automatic spi_frame(input logic [15:0] word, input int n, output int rise_cyc);
        logic [31:0] v;
        v = {word, 16'h0000};
        ncs = 1'b0;
        tick(4);
        for (int i = 0; i < n; i++) begin
            sdi = v[31-i];
            tick(4);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        tick(4);
        ncs = 1'b1;
        rise_cyc = cyc;
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [7:0] d, input int rise_cyc);
        exp_t e;
        e.is_err = 1'b0;
        e.addr = a;
        e.data = d;
        e.cyc = rise_cyc + 3;
        exp_q.push_back(e);
        held_addr = a;
        held_data = d;
    endtask

    task automatic push_err(input int rise_cyc);
        exp_t e;
        e.is_err = 1'b1;
        e.addr = held_addr;
        e.data = held_data;
        e.cyc = rise_cyc + 3;
        exp_q.push_back(e);
    endtask

    // Monitor: pops an expectation whenever a strobe is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr_valid || frame_err) begin
                check("strobe_exclusive", int'(wr_valid & frame_err), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {31'd0, wr_valid}, {31'd0, frame_err});
                    n_total++;
                    $display("FAIL unexpected_strobe: wr_valid=%0b frame_err=%0b at cycle %0d, expected none",
                             wr_valid, frame_err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind_err", int'(frame_err), int'(e.is_err));
                    check("strobe_cycle", cyc, e.cyc);
                    check("strobe_addr", int'(wr_addr), int'(e.addr));
                    check("strobe_data", int'(wr_data), int'(e.data));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500us;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int rc;
        n_total = 0;
        n_pass = 0;
        cyc = 0;
        held_addr = '0;
        held_data = '0;
        rst = 1'b1;
        sclk = 1'b0;
        ncs = 1'b1;
        sdi = 1'b0;
        tick(3);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_valid", int'(wr_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        rst = 1'b0;
        tick(10);

        // Valid write at the address limit.
        spi_frame(16'h84A5, 16, rc);
        push_wr(7'h04, 8'hA5, rc);
        tick(10);

        // Read frame: discarded silently.
        spi_frame(16'h0312, 16, rc);
        tick(10);
        check("read_busy_idle", int'(busy), 0);
        check("read_hold_addr", int'(wr_addr), 7'h04);
        check("read_hold_data", int'(wr_data), 8'hA5);

        // Short frame (15 bits) and overflow frame (17 bits).
        spi_frame(16'h84A5, 15, rc);
        push_err(rc);
        tick(10);
        spi_frame(16'h84A5, 17, rc);
        push_err(rc);
        tick(10);

        // Write to out-of-range address.
        spi_frame(16'h85FF, 16, rc);
        push_err(rc);
        tick(10);
        check("badaddr_hold_addr", int'(wr_addr), 7'h04);
        check("badaddr_hold_data", int'(wr_data), 8'hA5);

        // Reset mid-frame with ncs held low across reset release.
        ncs = 1'b0;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            sdi = i[0];
            tick(4);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        rst = 1'b1;
        tick(2);
        check("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        held_addr = '0;
        held_data = '0;
        tick(10);
        check("postrst_busy", int'(busy), 0);
        check("postrst_wr_addr", int'(wr_addr), 0);
        check("postrst_wr_data", int'(wr_data), 0);
        ncs = 1'b1;
        tick(6);
        spi_frame(16'h8133, 16, rc);
        push_wr(7'h01, 8'h33, rc);
        tick(10);

        // Back-to-back writes with minimum ncs-high gap.
        spi_frame(16'h8011, 16, rc);
        push_wr(7'h00, 8'h11, rc);
        tick(4);
        spi_frame(16'h8122, 16, rc);
        push_wr(7'h01, 8'h22, rc);
        tick(10);
        check("final_busy", int'(busy), 0);
        check("final_wr_addr", int'(wr_addr), 7'h01);
        check("final_wr_data", int'(wr_data), 8'h22);

        check("missing_strobes", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, number of synchronizer flops per asynchronous SPI input (legal range 2-4).
REQ-002 SHALL provide parameter MAX_ADDR, default 7'h04, highest register address accepted for a write.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic in this domain.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port sclk, input, 1 bit, SPI serial clock (mode 0), asynchronous to clk.
REQ-006 SHALL have port ncs, input, 1 bit, SPI chip select, active-low, asynchronous to clk.
REQ-007 SHALL have port sdi, input, 1 bit, SPI serial data in, asynchronous to clk.
REQ-008 SHALL have port wr_valid, output, 1 bit, one-cycle strobe marking a committed register write.
REQ-009 SHALL have port wr_addr, output, 7 bits, address of the last committed write.
REQ-010 SHALL have port wr_data, output, 8 bits, data of the last committed write.
REQ-011 SHALL have port frame_err, output, 1 bit, one-cycle strobe marking a rejected frame.
REQ-012 SHALL have port busy, output, 1 bit, high while a frame is being received or committed.

Function
REQ-013 SHALL pass sclk, ncs and sdi each through SYNC_STAGES flops, plus one history flop on sclk and ncs for edge detection.
REQ-014 SHALL detect sclk rise as synced sclk=1 and history=0; ncs fall/rise likewise.
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-016 IDLE -> SHIFT on synced ncs falling edge; on that transition shift register and bit counter clear to 0.
REQ-017 In SHIFT, each sclk rise with synced ncs=0 in the same cycle shifts synced sdi into bit 0, MSB first, and increments the 5-bit bit counter, saturating at 17.
REQ-018 SHIFT -> DONE on synced ncs rising edge; an sclk rise in that same cycle is ignored.
REQ-019 DONE -> IDLE unconditionally after one cycle; busy = (state != IDLE).
REQ-020 Frame format: bit 15 R/W (1 = write), bits 14:8 address, bits 7:0 data.
REQ-021 In DONE: count=16, R/W=1, address <= MAX_ADDR -> wr_valid=1, and wr_addr/wr_data load the frame fields on the edge entering DONE.
REQ-022 In DONE: count=16, R/W=0 -> read frame silently discarded, no strobe.
REQ-023 In DONE: count != 16 (short, or saturated at 17 = overflow), or write with address > MAX_ADDR -> frame_err=1, wr_addr/wr_data unchanged.
REQ-024 wr_valid and frame_err SHALL never be high in the same cycle; each is high for exactly one clk cycle per frame.
REQ-025 Latency: strobe is high in the cycle after the (SYNC_STAGES+1)th clk edge following the ncs pin rise (3 edges at default).
REQ-026 wr_addr/wr_data SHALL hold their value between commits.
REQ-027 Back-to-back frames SHALL be accepted provided ncs stays high for at least SYNC_STAGES+2 clk cycles.
REQ-028 sclk SHALL be at most clk/4 for correct sampling; faster sclk is out of scope.

Reset
REQ-029 While rst=1: state IDLE, counter and shift register 0, wr_valid=0, frame_err=0, busy=0, wr_addr=0, wr_data=0.
REQ-030 While rst=1: ncs synchronizer and history flops reset to 1; sclk and sdi flops reset to 0.
REQ-031 Reset mid-frame SHALL abort the frame with no strobe; if ncs is low when rst deasserts, no frame starts until ncs goes high and then low again.

Verification
REQ-032 Write frame 16'h84A5, sclk = clk/8 -> wr_valid one cycle, wr_addr=7'h04, wr_data=8'hA5, frame_err=0, pulse 3 clk edges after ncs rise.
REQ-033 Read frame 16'h0312 -> no wr_valid, no frame_err; wr_addr/wr_data keep previous value; busy returns 0.
REQ-034 15 sclk pulses, then ncs rise -> frame_err one cycle, no wr_valid; 17 pulses -> frame_err one cycle.
REQ-035 Write frame 16'h85FF (address 0x05 > MAX_ADDR) -> frame_err one cycle, wr_addr/wr_data unchanged.
REQ-036 rst pulsed after 8 bits with ncs held low -> busy=0, no strobe; then ncs high, full frame 16'h8133 -> wr_valid, wr_addr=7'h01, wr_data=8'h33.
REQ-037 Two write frames 16'h8011 and 16'h8122 with ncs high for 4 clk cycles between -> two wr_valid pulses, values in order.
